microtile_pwm_bank: RTL



---
 rtl/microtile_pwm_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/microtile_pwm_bank.sv
// Multi-channel PWM bank sharing one period counter. Duty changes are shadowed
// and commit at period wrap. Config arrives as strobed writes on a 2-flop synced bus.
module microtile_pwm_bank #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CMAX = '1;

    logic [7:0]          s1;
    logic [7:0]          s2;
    logic                strobe_q;
    logic [2:0]          addr;
    logic [WIDTH-1:0]    shadow_duty [CHANNELS];
    logic [WIDTH-1:0]    active_duty [CHANNELS];
    logic [CHANNELS-1:0] inv;
    logic [PW-1:0]       pcnt;
    logic [WIDTH-1:0]    cnt;
    logic [7:0]          pwm_next;

    logic fire;
    logic wr_addr;
    logic wr_data;
    logic tick;
    logic wrap;
    logic unused_bits;

    assign fire    = s2[7] & ~strobe_q;
    assign wr_addr = fire & ~s2[6];
    assign wr_data = fire & s2[6];
    assign tick    = ena && (pcnt == PMAX);
    assign wrap    = tick && (cnt == CMAX);

    // Payload bits above WIDTH-1 are deliberately dropped.
    assign unused_bits = &{1'b0, s2[4:0]};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            strobe_q <= 1'b0;
            addr     <= '0;
        end else begin
            s1       <= ui_in;
            s2       <= s1;
            strobe_q <= s2[7];
            if (wr_addr) begin
                addr <= s2[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (ena) begin
            pcnt <= (pcnt == PMAX) ? '0 : pcnt + 1'b1;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // NOTE: the duty arrays are reset explicitly so every channel starts at duty 0, not X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_duty[i] <= '0;
                active_duty[i] <= '0;
            end
            inv <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // A write on the wrap edge lands in shadow only; active takes the old shadow.
                if (wrap) begin
                    active_duty[i] <= shadow_duty[i];
                end
                if (wr_data && (addr == 3'(i))) begin
                    shadow_duty[i] <= s2[WIDTH-1:0];
                    inv[i]         <= s2[5];
                end
            end
        end
    end

    // NOTE: pwm_next gets a default before the loop so no latch is inferred for unused bits.
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_next[i] = (cnt < active_duty[i]) ^ inv[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out <= '0;
        end else begin
            uo_out <= pwm_next;
        end
    end

endmodule
